// File: rtl/bcd_serial_add_seq_pkg.sv
// Shared definitions for the serial BCD adder sequencer.
//   DIGIT_W   bits per BCD digit
//   BCD_MAX   largest legal digit value
//   S_*       sequencer state encodings
//   digit_bad flags a nibble that is not a legal BCD digit
package bcd_serial_add_seq_pkg;

  localparam int                 DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_adder.sv
// Single-digit combinational BCD adder.
//   cin   carry in
//   a, b  BCD digits (0..9)
//   bcd0  units digit of a+b+cin
//   bcd1  tens digit of a+b+cin (always 0 or 1)
module bcd_adder
  import bcd_serial_add_seq_pkg::*;
(
  input  logic               cin,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic [DIGIT_W-1:0] bcd0,
  output logic [DIGIT_W-1:0] bcd1
);

  logic [DIGIT_W:0] bin;

  assign bin = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};

  // For binary sums 10..19, adding 6 and dropping bit 4 yields sum-10.
  always_comb begin
    bcd0 = bin[DIGIT_W-1:0];
    bcd1 = '0;
    if (bin > {1'b0, BCD_MAX}) begin
      bcd0 = bin[DIGIT_W-1:0] + 4'd6;
      bcd1 = 4'd1;
    end
  end

endmodule

// File: rtl/bcd_serial_add_seq.sv
// Multi-digit BCD add sequencer sharing one bcd_adder, one digit per clock,
// least significant digit first.
//   clk, rst  clock, synchronous active-high reset
//   start     request, sampled only while ready
//   a, b, cin packed BCD operands (digit 0 in [3:0]) and carry in
//   ready     idle, can accept start
//   busy      digit steps in progress
//   done      one-cycle result-valid pulse
//   sum, cout packed BCD result and carry out, held until next accepted start
//   err       some operand digit was >9 (sum/cout then forced to 0)
module bcd_serial_add_seq
  import bcd_serial_add_seq_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIGIT_W*NDIG-1:0] a,
  input  logic [DIGIT_W*NDIG-1:0] b,
  input  logic                  cin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DIGIT_W*NDIG-1:0] sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W     = DIGIT_W * NDIG;
  localparam int IDX_W = $clog2(NDIG) + 1;

  logic [1:0]         state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [W-1:0]       sa, sb;
  logic [2*W-1:0]     ops;
  logic [2*NDIG-1:0]  dig_bad;
  logic [DIGIT_W-1:0] add_lo, add_hi;

  // Operand check looks at the live inputs: it only matters on the accepting edge.
  assign ops = {b, a};
  for (genvar g = 0; g < 2*NDIG; g++) begin : g_chk
    assign dig_bad[g] = digit_bad(ops[g*DIGIT_W +: DIGIT_W]);
  end

  // Shift registers present the current digit pair at their bottom nibble.
  bcd_adder u_add (
    .cin  (carry),
    .a    (sa[DIGIT_W-1:0]),
    .b    (sb[DIGIT_W-1:0]),
    .bcd0 (add_lo),
    .bcd1 (add_hi)
  );

  assign ready = (state == S_IDLE);
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            if (|dig_bad) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              err   <= 1'b0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          sa    <= sa >> DIGIT_W;
          sb    <= sb >> DIGIT_W;
          carry <= (add_hi != '0);
          for (int d = 0; d < NDIG; d++) begin
            if (idx == IDX_W'(d)) sum[d*DIGIT_W +: DIGIT_W] <= add_lo;
          end
          if (idx == IDX_W'(NDIG-1)) begin
            cout  <= (add_hi != '0);
            idx   <= '0;
            state <= S_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_seq.sv
module tb_bcd_serial_add_seq;
  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         ready, busy, done, cout, err;
  logic [W-1:0] sum;

  bcd_serial_add_seq #(.NDIG(NDIG)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: operands as decimal integers.
  function automatic bit ops_ok(input logic [W-1:0] v);
    for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = NDIG-1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci, input int acc_cyc);
    exp_t   e;
    longint pw = 1;
    longint tot;
    for (int i = 0; i < NDIG; i++) pw = pw * 10;
    if (!ops_ok(av) || !ops_ok(bv)) begin
      e.sum = '0; e.cout = 1'b0; e.err = 1'b1; e.cyc = acc_cyc;
    end else begin
      tot    = bcd2int(av) + bcd2int(bv) + longint'(ci);
      e.sum  = int2bcd(tot % pw);
      e.cout = (tot >= pw);
      e.err  = 1'b0;
      e.cyc  = acc_cyc + NDIG;
    end
    return e;
  endfunction

  // Monitor: scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_busy_done_onehot", 32'(ready) + 32'(busy) + 32'(done), 32'd1);
      if (done) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 sum=%0h, expected no done (cycle %0d)", sum, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sum",        32'(sum),  32'(e.sum));
          check("cout",       32'(cout), 32'(e.cout));
          check("err",        32'(err),  32'(e.err));
          check("done_cycle", 32'(cyc),  32'(e.cyc));
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = ready;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0, expected ready=1 within 50 cycles");
    end
  endtask

  // Issue one operation; keep=1 leaves start asserted afterwards.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input bit keep);
    bit   ok;
    exp_t e;
    wait_ready(ok);
    if (!ok) return;
    a = av; b = bv; cin = ci; start = 1'b1;
    @(posedge clk);
    #1;
    e = model(av, bv, ci, cyc);
    q.push_back(e);
    if (!keep) start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'(!e.err));
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || !ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0 || !ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", q.size());
    end
  endtask

  function automatic logic [W-1:0] rand_ops(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < NDIG; i++)
      v[4*i +: 4] = (allow_bad && $urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                                : 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    bit ok;
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    bit ok;
    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_sum",   32'(sum),   32'd0);
    check("rst_cout",  32'(cout),  32'd0);
    check("rst_err",   32'(err),   32'd0);
    start = 1'b0;
    rst   = 1'b0;

    // Directed cases.
    do_op(16'h0003, 16'h0005, 1'b0, 1'b0);
    do_op(16'h0009, 16'h0005, 1'b0, 1'b0);
    do_op(16'h0003, 16'h0009, 1'b1, 1'b0);
    do_op(16'h9999, 16'h0001, 1'b0, 1'b0);
    do_op(16'h9999, 16'h9999, 1'b1, 1'b0);
    do_op(16'h000A, 16'h0005, 1'b0, 1'b0);
    do_op(16'h0000, 16'hF000, 1'b1, 1'b0);
    drain();

    // Start during RUN at edge T+2 is ignored.
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h8888; b = 16'h8888; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    drain();
    check("sum_held_after_done", 32'(sum), 32'h3333);

    // Reset at edge T+2 aborts without a done pulse.
    wait_ready(ok);
    a = 16'h5678; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_sum",   32'(sum),   32'd0);
    check("abort_cout",  32'(cout),  32'd0);
    check("abort_err",   32'(err),   32'd0);
    repeat (8) @(negedge clk);
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    drain();

    // Start held high: back-to-back acceptance on each return to IDLE.
    for (int i = 0; i < 6; i++)
      do_op(rand_ops(1'b1), rand_ops(1'b1), 1'($urandom), (i != 5));
    drain();

    // Randomized traffic with idle gaps.
    for (int i = 0; i < 40; i++) begin
      do_op(rand_ops(1'b1), rand_ops(1'b1), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
